// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: owns the gshare speculative branch history and funnels
// retired branch outcomes through an in-order FIFO into the predictor's
// single write port.
module bp_update_ctrl #(
  parameter  int unsigned DEPTH    = 16,
  parameter  int unsigned N_RETIRE = 2,
  parameter  int unsigned Q_DEPTH  = 4,
  parameter  int unsigned ADDR     = 32,
  localparam int unsigned L        = $clog2(DEPTH),
  localparam int unsigned CW       = $clog2(Q_DEPTH) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  // fetch-side read path
  input  logic                     fetch_valid,
  input  logic [ADDR-1:0]          fetch_pc,
  output logic [ADDR-1:0]          rd_pc,
  output logic [L-1:0]             rd_bhr,
  input  logic                     pred_in,
  output logic                     pred_taken,
  output logic [L-1:0]             pred_bhr,
  // mispredict recovery
  input  logic                     mispredict,
  input  logic [L-1:0]             mis_bhr,
  input  logic                     mis_taken,
  // retire lanes
  input  logic [N_RETIRE-1:0]      rt_valid,
  input  logic [N_RETIRE*ADDR-1:0] rt_pc,
  input  logic [N_RETIRE*L-1:0]    rt_bhr,
  input  logic [N_RETIRE-1:0]      rt_taken,
  output logic                     rt_ready,
  // predictor write port
  output logic                     wr_en,
  output logic [ADDR-1:0]          wr_pc,
  output logic [L-1:0]             wr_bhr,
  output logic                     wr_taken,
  // status
  output logic [L-1:0]             spec_bhr,
  output logic [CW-1:0]            q_count
);

  localparam int unsigned PW = $clog2(Q_DEPTH);

  typedef struct packed {
    logic [ADDR-1:0] pc;
    logic [L-1:0]    bhr;
    logic            taken;
  } upd_t;

  upd_t          mem [Q_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] lane_slot [N_RETIRE];
  logic [CW-1:0] enq_cnt;
  logic [CW-1:0] enq_num;
  upd_t          head_e;

  // Read path passes straight through to the predictor and back to fetch.
  always_comb begin
    rd_pc      = fetch_pc;
    rd_bhr     = spec_bhr;
    pred_taken = pred_in;
    pred_bhr   = spec_bhr;
  end

  // Speculative history: mispredict recovery wins over a same-cycle fetch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      spec_bhr <= '0;
    end else if (mispredict) begin
      spec_bhr <= {mis_bhr[L-2:0], mis_taken};
    end else if (fetch_valid) begin
      spec_bhr <= {spec_bhr[L-2:0], pred_in};
    end
  end

  // Space check uses only the registered count; a same-cycle pop is not credited.
  always_comb begin
    rt_ready = (q_count <= CW'(Q_DEPTH - N_RETIRE));
  end

  // Pack valid lanes from the tail upward, lane 0 oldest.
  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < N_RETIRE; i++) begin
      lane_slot[i] = tail + enq_cnt[PW-1:0];
      enq_cnt      = enq_cnt + CW'(rt_valid[i]);
    end
    enq_num = rt_ready ? enq_cnt : '0;
  end

  // Entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_RETIRE; i++) begin
      if (rt_ready && rt_valid[i]) begin
        mem[lane_slot[i]] <= '{pc:    rt_pc[i*ADDR +: ADDR],
                               bhr:   rt_bhr[i*L +: L],
                               taken: rt_taken[i]};
      end
    end
  end

  // Pointers and occupancy; the predictor accepts a write every cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      q_count <= '0;
    end else begin
      tail    <= tail + PW'(enq_num);
      if (wr_en) begin
        head <= head + PW'(1);
      end
      q_count <= q_count + enq_num - CW'(wr_en);
    end
  end

  // Head entry drives the predictor write port whenever the FIFO holds data.
  always_comb begin
    head_e   = mem[head];
    wr_en    = (q_count != '0);
    wr_pc    = head_e.pc;
    wr_bhr   = head_e.bhr;
    wr_taken = head_e.taken;
  end

endmodule
